// File: rtl/wdg_win_pkg.sv
// Shared types and constants for the windowed watchdog core.
package wdg_win_pkg;

    localparam int unsigned KEY_W = 16;
    localparam logic [KEY_W-1:0] FEED_KEY_DEF = 16'hA5C3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WARN = 2'd2,
        ST_BITE = 2'd3
    } wdg_state_e;

    // Channel-select width; a single-channel core still carries a 1-bit index.
    function automatic int unsigned ch_sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wdg_win_core_if.sv
// Configuration, feed and status bundle between the register shim and the watchdog core.
interface wdg_win_core_if #(
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned PSC_WIDTH = 16
);
    import wdg_win_pkg::*;

    localparam int unsigned CH_W = ch_sel_w(CH_NUM);

    logic [PSC_WIDTH-1:0]        psc_i;
    logic [CH_NUM-1:0]           en_i;
    logic [CH_NUM*CNT_WIDTH-1:0] load_i;
    logic [CH_NUM*CNT_WIDTH-1:0] win_i;
    logic                        feed_vld_i;
    logic [CH_W-1:0]             feed_ch_i;
    logic [KEY_W-1:0]            feed_key_i;
    logic [CH_NUM-1:0]           clr_i;
    logic [CH_NUM*CNT_WIDTH-1:0] cnt_o;
    logic [CH_NUM-1:0]           irq_o;
    logic [CH_NUM-1:0]           err_o;
    logic                        rst_req_o;

    modport master (
        output psc_i, en_i, load_i, win_i, feed_vld_i, feed_ch_i, feed_key_i, clr_i,
        input  cnt_o, irq_o, err_o, rst_req_o
    );

    modport slave (
        input  psc_i, en_i, load_i, win_i, feed_vld_i, feed_ch_i, feed_key_i, clr_i,
        output cnt_o, irq_o, err_o, rst_req_o
    );

endinterface

// File: rtl/wdg_win_ch.sv
// One watchdog channel: state machine, down-counter, feed-window check and sticky flags.
module wdg_win_ch
    import wdg_win_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 tick,
    input  logic                 feed,
    input  logic                 key_ok,
    input  logic                 clr,
    input  logic [CNT_WIDTH-1:0] load,
    input  logic [CNT_WIDTH-1:0] win,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 irq,
    output logic                 err,
    output logic                 bite_nxt_c
);

    wdg_state_e           state_q;
    wdg_state_e           state_d;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 irq_set;
    logic                 err_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt     <= '0;
            irq     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt_d;
            irq     <= irq_set | (irq & ~clr);
            err     <= err_set | (err & ~clr);
        end
    end

    // A good in-window feed takes priority over a coincident tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt;
        irq_set = 1'b0;
        err_set = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    cnt_d   = load;
                end
                ST_RUN, ST_WARN: begin
                    if (feed && key_ok && (cnt <= win)) begin
                        state_d = ST_RUN;
                        cnt_d   = load;
                    end else if (feed && key_ok) begin
                        state_d = ST_BITE;
                        err_set = 1'b1;
                    end else begin
                        err_set = feed;
                        if (tick) begin
                            if (cnt == '0) begin
                                if (state_q == ST_RUN) begin
                                    irq_set = 1'b1;
                                    cnt_d   = load;
                                    state_d = ST_WARN;
                                end else begin
                                    state_d = ST_BITE;
                                end
                            end else begin
                                cnt_d = cnt - CNT_WIDTH'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_BITE;
                end
            endcase
        end
    end

    assign bite_nxt_c = (state_d == ST_BITE);

endmodule

// File: rtl/wdg_win_core.sv
// Multi-channel windowed watchdog: shared prescaler, feed decode and reset-request reduction.
module wdg_win_core
    import wdg_win_pkg::*;
#(
    parameter int unsigned      CH_NUM    = 4,
    parameter int unsigned      CNT_WIDTH = 32,
    parameter int unsigned      PSC_WIDTH = 16,
    parameter logic [KEY_W-1:0] FEED_KEY  = FEED_KEY_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wdg_win_core_if.slave  bus
);

    localparam int unsigned CH_W = ch_sel_w(CH_NUM);

    logic [PSC_WIDTH-1:0]        psc_q;
    logic                        any_en;
    logic                        tick_c;
    logic                        key_ok;
    logic [CH_NUM-1:0]           bite_nxt;
    logic [CH_NUM*CNT_WIDTH-1:0] cnt_w;
    logic [CH_NUM-1:0]           irq_w;
    logic [CH_NUM-1:0]           err_w;
    logic                        rst_req_q;

    assign any_en = |bus.en_i;
    assign tick_c = any_en && (psc_q >= bus.psc_i);
    assign key_ok = (bus.feed_key_i == FEED_KEY);

    // Free-running while any channel is enabled; >= lets a lowered divisor wrap at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            psc_q <= '0;
        end else if (!any_en || tick_c) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_q + PSC_WIDTH'(1);
        end
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        wdg_win_ch #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk        (clk_i),
            .rst        (rst_i),
            .en         (bus.en_i[k]),
            .tick       (tick_c),
            .feed       (bus.feed_vld_i && (bus.feed_ch_i == CH_W'(k))),
            .key_ok     (key_ok),
            .clr        (bus.clr_i[k]),
            .load       (bus.load_i[k*CNT_WIDTH +: CNT_WIDTH]),
            .win        (bus.win_i[k*CNT_WIDTH +: CNT_WIDTH]),
            .cnt        (cnt_w[k*CNT_WIDTH +: CNT_WIDTH]),
            .irq        (irq_w[k]),
            .err        (err_w[k]),
            .bite_nxt_c (bite_nxt[k])
        );
    end

    // Registered from next-state so the request rises with the BITE transition.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rst_req_q <= 1'b0;
        end else begin
            rst_req_q <= |bite_nxt;
        end
    end

    assign bus.cnt_o     = cnt_w;
    assign bus.irq_o     = irq_w;
    assign bus.err_o     = err_w;
    assign bus.rst_req_o = rst_req_q;

endmodule

// File: tb/tb_wdg_win_core.sv
// Scoreboard bench for wdg_win_core: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_wdg_win_core;
    import wdg_win_pkg::*;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 32;
    localparam int unsigned PW = 16;
    localparam logic [15:0] GOOD = 16'hA5C3;
    localparam int S_CNT = 0, S_IRQ = 1, S_ERR = 2, S_RRQ = 3;

    typedef struct {
        int          due;
        int          sel;
        int          ch;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    wdg_win_core_if #(.CH_NUM(CH), .CNT_WIDTH(CW), .PSC_WIDTH(PW)) bus ();

    wdg_win_core #(
        .CH_NUM    (CH),
        .CNT_WIDTH (CW),
        .PSC_WIDTH (PW),
        .FEED_KEY  (GOOD)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sel_name(input int s);
        case (s)
            S_CNT:   return "cnt";
            S_IRQ:   return "irq";
            S_ERR:   return "err";
            default: return "rst_req";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int s, input int ch);
        case (s)
            S_CNT:   return bus.cnt_o[ch*CW +: CW];
            S_IRQ:   return 32'(bus.irq_o);
            S_ERR:   return 32'(bus.err_o);
            default: return 32'(bus.rst_req_o);
        endcase
    endfunction

    // Insert keeping the queue ordered by due cycle.
    task automatic expect_at(input int due, input int sel, input int ch, input logic [31:0] val);
        exp_t e;
        int   pos;
        e.due = due; e.sel = sel; e.ch = ch; e.val = val;
        pos = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].due > due) begin
                pos = i;
                break;
            end
        end
        q.insert(pos, e);
    endtask

    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed(input int ch, input logic [15:0] key);
        bus.feed_vld_i = 1'b1;
        bus.feed_ch_i  = 2'(ch);
        bus.feed_key_i = key;
        @(posedge clk);
        #1;
        bus.feed_vld_i = 1'b0;
        bus.feed_key_i = 16'h0000;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] ld, input logic [31:0] w);
        bus.load_i[ch*CW +: CW] = ld;
        bus.win_i[ch*CW +: CW]  = w;
    endtask

    task automatic cleanup();
        bus.en_i = '0;
        @(posedge clk); #1;
        bus.clr_i = '1;
        @(posedge clk); #1;
        bus.clr_i = '0;
        @(posedge clk); #1;
    endtask

    // Monitor: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            a = actual(e.sel, e.ch);
            checks++;
            if (e.due != cyc || a !== e.val) begin
                errors++;
                $display("FAIL %s[%0d] due cyc %0d seen cyc %0d: got %0h, expected %0h",
                         sel_name(e.sel), e.ch, e.due, cyc, a, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        bus.psc_i      = 16'd1;
        bus.en_i       = '0;
        bus.load_i     = '0;
        bus.win_i      = '0;
        bus.feed_vld_i = 1'b0;
        bus.feed_ch_i  = '0;
        bus.feed_key_i = '0;
        bus.clr_i      = '0;

        // Reset state
        goto(3);
        expect_at(3, S_CNT, 0, 0);
        expect_at(3, S_IRQ, 0, 0);
        expect_at(3, S_ERR, 0, 0);
        expect_at(3, S_RRQ, 0, 0);
        goto(4);
        rst = 1'b0;

        // Basic expiry, psc=1, load=9: decrement every 2nd edge, irq 20 edges after load, bite 20 later
        b = cyc;
        set_ch(0, 32'd9, 32'hFFFF_FFFF);
        bus.en_i = 4'b0001;
        expect_at(b + 1,  S_CNT, 0, 9);
        expect_at(b + 2,  S_CNT, 0, 8);
        expect_at(b + 18, S_CNT, 0, 0);
        expect_at(b + 19, S_IRQ, 0, 0);
        expect_at(b + 20, S_IRQ, 0, 32'h1);
        expect_at(b + 20, S_CNT, 0, 9);
        expect_at(b + 39, S_RRQ, 0, 0);
        expect_at(b + 40, S_RRQ, 0, 1);
        expect_at(b + 40, S_CNT, 0, 0);
        expect_at(b + 40, S_ERR, 0, 0);
        expect_at(b + 46, S_CNT, 0, 0);
        goto(b + 46);
        bus.en_i = 4'b0000;
        expect_at(b + 47, S_RRQ, 0, 0);
        expect_at(b + 47, S_IRQ, 0, 32'h1);
        expect_at(b + 47, S_CNT, 0, 0);
        goto(b + 47);
        bus.clr_i = 4'b0001;
        expect_at(b + 48, S_IRQ, 0, 0);
        goto(b + 48);
        bus.clr_i = 4'b0000;
        cleanup();

        // Windowed feed, psc=0: in-window feed coincides with a tick and must reload
        bus.psc_i = 16'd0;
        b = cyc;
        set_ch(0, 32'd100, 32'd40);
        bus.en_i = 4'b0001;
        expect_at(b + 71, S_CNT, 0, 30);
        expect_at(b + 72, S_CNT, 0, 100);
        expect_at(b + 72, S_ERR, 0, 0);
        expect_at(b + 73, S_CNT, 0, 99);
        expect_at(b + 112, S_CNT, 0, 60);
        expect_at(b + 113, S_ERR, 0, 32'h1);
        expect_at(b + 113, S_RRQ, 0, 1);
        goto(b + 71);
        feed(0, GOOD);
        goto(b + 112);
        feed(0, GOOD);
        expect_at(b + 114, S_RRQ, 0, 0);
        expect_at(b + 115, S_ERR, 0, 0);
        cleanup();

        // Bad key inside the window; then a bad key to a disabled channel is ignored
        b = cyc;
        set_ch(0, 32'd20, 32'd40);
        bus.en_i = 4'b0001;
        expect_at(b + 11, S_CNT, 0, 10);
        expect_at(b + 12, S_ERR, 0, 32'h1);
        expect_at(b + 12, S_CNT, 0, 9);
        expect_at(b + 13, S_CNT, 0, 8);
        expect_at(b + 15, S_ERR, 0, 32'h1);
        goto(b + 11);
        feed(0, 16'h0000);
        goto(b + 14);
        feed(3, 16'h0000);
        cleanup();

        // Isolation: ch2 expires (clear in the same cycle loses), others fed
        b = cyc;
        set_ch(0, 32'd50, 32'hFFFF_FFFF);
        set_ch(1, 32'd50, 32'hFFFF_FFFF);
        set_ch(3, 32'd50, 32'hFFFF_FFFF);
        set_ch(2, 32'd5,  32'hFFFF_FFFF);
        bus.en_i = 4'b1111;
        expect_at(b + 7,  S_IRQ, 0, 32'h4);
        expect_at(b + 11, S_CNT, 0, 50);
        expect_at(b + 12, S_RRQ, 0, 0);
        expect_at(b + 13, S_RRQ, 0, 1);
        expect_at(b + 13, S_CNT, 2, 0);
        expect_at(b + 20, S_CNT, 0, 41);
        expect_at(b + 20, S_CNT, 1, 42);
        expect_at(b + 20, S_CNT, 2, 0);
        expect_at(b + 20, S_CNT, 3, 43);
        expect_at(b + 20, S_IRQ, 0, 32'h4);
        expect_at(b + 20, S_ERR, 0, 0);
        goto(b + 6);
        bus.clr_i = 4'b0100;
        goto(b + 7);
        bus.clr_i = 4'b0000;
        goto(b + 10);
        feed(0, GOOD);
        feed(1, GOOD);
        feed(3, GOOD);
        goto(b + 20);
        cleanup();

        // Async reset in WARN (ch1 with load=0 already in BITE), then reload after release
        b = cyc;
        set_ch(0, 32'd3, 32'hFFFF_FFFF);
        set_ch(1, 32'd0, 32'hFFFF_FFFF);
        bus.en_i = 4'b0011;
        expect_at(b + 5, S_IRQ, 0, 32'h3);
        expect_at(b + 5, S_CNT, 0, 3);
        expect_at(b + 5, S_RRQ, 0, 1);
        expect_at(b + 6, S_IRQ, 0, 0);
        expect_at(b + 6, S_CNT, 0, 0);
        expect_at(b + 6, S_RRQ, 0, 0);
        expect_at(b + 8, S_CNT, 0, 3);
        expect_at(b + 9, S_CNT, 0, 2);
        goto(b + 6);
        rst = 1'b1;
        goto(b + 7);
        rst = 1'b0;
        goto(b + 10);

        goto(cyc + 3);
        if (q.size() > 0) begin
            $display("FAIL pending: %0d expectations never checked", q.size());
            errors += q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wdg_win_core.md
# wdg_win_core

Parametrised multi-channel windowed watchdog core, the successor to the single-channel watchdog. It provides CH_NUM independent down-counters sharing one prescaler. Each channel has a programmable feed window, a keyed feed, and a two-stage expiry: a warning IRQ first, then a reset request. It sits behind the APB4 register shim, which drives its configuration and feed inputs; the core itself has no bus logic.

## Interface
- CH_NUM, 4: number of watchdog channels (1..16)
- CNT_WIDTH, 32: counter, load and window width
- PSC_WIDTH, 16: prescaler width
- FEED_KEY, 16'hA5C3: value feed_key_i must carry for a valid feed
- clk_i  in  1  core clock; all logic single clock domain
- rst_i  in  1  reset, asynchronous, active-high
- psc_i  in  PSC_WIDTH  prescaler divisor minus one (tick every psc_i+1 cycles)
- en_i  in  CH_NUM  per-channel enable
- load_i  in  CH_NUM*CNT_WIDTH  per-channel reload value, channel k at [k*CNT_WIDTH +: CNT_WIDTH]
- win_i  in  CH_NUM*CNT_WIDTH  per-channel window threshold; feed legal only when count <= win
- feed_vld_i  in  1  feed strobe, one cycle
- feed_ch_i  in  $clog2(CH_NUM) (min 1)  target channel
- feed_key_i  in  16  feed key
- clr_i  in  CH_NUM  clear irq_o/err_o flags of channel k
- cnt_o  out  CH_NUM*CNT_WIDTH  live counter values
- irq_o  out  CH_NUM  sticky stage-1 warning flag
- err_o  out  CH_NUM  sticky feed-error flag (bad key or early feed)
- rst_req_o  out  1  OR of all channels in BITE

## Operation
- Prescaler: free-running PSC_WIDTH counter while any en_i bit is set. It is held at 0 when all channels are disabled. When it reaches psc_i, it wraps and pulses tick for one cycle.
- Per-channel FSM states: IDLE, RUN, WARN, BITE.
- IDLE to RUN: en_i[k] sampled high; the counter is loaded with load_i[k] in the same cycle.
- RUN, tick with cnt==0: set irq_o[k], reload load_i[k], go to WARN.
- WARN, tick with cnt==0: go to BITE; the counter holds 0.
- Valid feed: feed_vld_i, channel addressed, key == FEED_KEY, state RUN or WARN, and cnt <= win_i[k]. It reloads load_i[k] and goes to RUN. irq_o is not cleared by a feed.
- Bad key to an enabled channel: set err_o[k]; no reload, no state change.
- Early feed (good key, cnt > win_i[k]): set err_o[k] and go to BITE.
- BITE is sticky. It is left only by rst_i or by en_i[k] low, which returns the channel to IDLE with cnt 0.
- en_i[k] low in any state: go to IDLE, cnt forced to 0; irq_o/err_o are retained.
- Feeds are ignored, with no error, when the channel is in IDLE or BITE or the index is >= CH_NUM.
- clr_i[k] clears irq_o[k] and err_o[k]. If a set event occurs in the same cycle, the set wins.
- Counters decrement by 1 per tick in RUN/WARN and never wrap below 0.
- win_i >= load_i means no early-feed check in practice. load_i = 0 means expiry on the first tick.

## Timing
- Reset values: all FSMs IDLE, cnt_o = 0, irq_o = 0, err_o = 0, rst_req_o = 0, prescaler = 0.
- All outputs are registered.
- Feed: the reload is visible on cnt_o the cycle after feed_vld_i.
- Tick and valid feed in the same cycle: the feed wins (reload, no decrement).
- Expiry: irq_o/rst_req_o rise one cycle after the tick cycle in which cnt was 0.
- Time from feed to warning: (load+1)*(psc_i+1) cycles.
- psc_i = 0: a tick every cycle. A psc_i change takes effect at the next wrap; the prescaler compares with >=, so lowering psc_i below the current count wraps immediately.
- rst_i mid-operation clears everything asynchronously. The first enable after release loads on the first clk_i edge.

## Structure
- Package wdg_win_pkg: state enum (IDLE/RUN/WARN/BITE), FEED_KEY default, key width constant.
- Sub-module wdg_win_ch: one channel's FSM, counter, window check and flags. It is instantiated CH_NUM times in a generate loop.
- wdg_win_core holds the shared prescaler, the feed decode and the rst_req_o reduction.

## Test plan
- Basic expiry: psc_i=1, load=9 on ch0, no feed -> irq_o[0] at 20 cycles after load; rst_req_o 20 cycles later. cnt_o[0] stays 0 in BITE.
- Windowed feed: load=100, win=40. Feed with the correct key at cnt=30 -> cnt_o reloads to 100 next cycle, state RUN, err_o=0. A second feed at cnt=60 -> err_o[0]=1 and rst_req_o=1.
- Bad key: feed_key_i=16'h0000 at cnt=10 inside the window -> err_o set, counter keeps decrementing, no reload.
- Channel isolation: CH_NUM=4, ch2 expires while ch0/1/3 are fed periodically -> only irq_o[2] is set. The other channels' counters are unaffected.
- Simultaneous events: feed and tick in the same cycle -> reload wins. clr_i[k] and an expiry in the same cycle -> irq_o stays 1.
- Reset/disable mid-run: rst_i pulse in WARN -> all outputs 0 asynchronously. en_i low in BITE -> rst_req_o drops the next cycle; re-enable reloads and restarts.
